alu_neg_finish: RTL and testbench

//   Downstream of the ALU byte-lane copier. The copier negates by ones'-complement only.

---
 rtl/alu_neg_finish.sv | 121 ++++++++++++
 tb/tb_alu_neg_finish.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_neg_finish.sv
// Completes two's-complement negation after the ones'-complement lane copier.
// Adds 1 across the selected byte lanes, one lane per cycle, with a registered carry.
module alu_neg_finish #(
  parameter int LANES  = 4,
  parameter int LANE_W = 8,
  localparam int DATA_W = LANES * LANE_W,
  localparam int IDX_W  = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_neg,
  input  logic [LANES-1:0]  in_sel,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_carry
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  lane;
  logic              carry;
  logic [DATA_W-1:0] data;
  logic [LANES-1:0]  sel;

  logic [LANE_W-1:0] cur;
  logic [LANE_W:0]   sum;
  logic              sel_bit;
  logic              last;
  logic              accept;
  logic              retire;

  always_comb begin
    cur     = data[lane*LANE_W +: LANE_W];
    sum     = {1'b0, cur} + {{LANE_W{1'b0}}, carry};
    sel_bit = sel[lane];
    last    = (lane == IDX_W'(LANES - 1));
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    retire    = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) begin
          state_nxt = in_neg ? BUSY : DONE;
        end
      end
      BUSY: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        retire    = out_ready;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane      <= '0;
      carry     <= 1'b0;
      data      <= '0;
      sel       <= '0;
      out_carry <= 1'b0;
    end else begin
      if (accept) begin
        data      <= in_data;
        sel       <= in_sel;
        out_carry <= 1'b0;
        lane      <= '0;
        carry     <= in_neg;
      end else if (state == BUSY) begin
        // Unselected lanes are skipped; the carry rides over them untouched.
        if (sel_bit) begin
          data[lane*LANE_W +: LANE_W] <= sum[LANE_W-1:0];
          carry <= sum[LANE_W];
        end
        if (last) begin
          lane      <= '0;
          out_carry <= sel_bit ? sum[LANE_W] : carry;
        end else begin
          lane <= lane + 1'b1;
        end
      end else if (retire) begin
        carry <= 1'b0;
      end
    end
  end

  assign out_data = data;

endmodule

// File: tb/tb_alu_neg_finish.sv
// Bench for alu_neg_finish: lane-gather reference model checked every cycle,
// plus directed vectors with literal expected results.
module tb_alu_neg_finish;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_neg = 1'b0;
  logic [3:0]  in_sel = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_carry;

  int checks = 0;
  int fails = 0;
  int cyc = 0;

  typedef struct {
    logic [32:0] res;
    int          due;
  } exp_t;

  exp_t q[$];

  alu_neg_finish #(.LANES(4), .LANE_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_neg(in_neg),
    .in_sel(in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_carry(out_carry)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Gather selected lanes into one contiguous number, add 1, scatter back.
  function automatic logic [32:0] model(input logic [31:0] d,
                                        input logic [3:0] s,
                                        input logic n);
    logic [39:0] packed_v;
    logic [31:0] res;
    int          k;
    logic        c;
    packed_v = '0;
    res = d;
    k = 0;
    if (!n) return {1'b0, d};
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        packed_v[k*8 +: 8] = d[i*8 +: 8];
        k++;
      end
    end
    packed_v = packed_v + 40'd1;
    c = packed_v[k*8];
    k = 0;
    for (int i = 0; i < 4; i++) begin
      if (s[i]) begin
        res[i*8 +: 8] = packed_v[k*8 +: 8];
        k++;
      end
    end
    return {c, res};
  endfunction

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      bit   idle;
      exp_t e;
      idle = (q.size() == 0);
      if (!idle && out_valid && out_ready) q.pop_front();
      if (idle && in_valid) begin
        e.res = model(in_data, in_sel, in_neg);
        e.due = cyc + (in_neg ? 5 : 1);
        q.push_back(e);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_ov;
      exp_ov = (q.size() > 0) && (cyc >= q[0].due);
      chk("mdl_in_ready", 64'(in_ready), 64'(q.size() == 0));
      chk("mdl_out_valid", 64'(out_valid), 64'(exp_ov));
      if (exp_ov) chk("mdl_result", 64'({out_carry, out_data}), 64'(q[0].res));
    end
  end

  task automatic run_op(input logic [31:0] d, input logic [3:0] s,
                        input logic n, input logic [31:0] ed,
                        input logic ec, input int hold, input bit mess);
    int lat;
    bit got;
    @(posedge clk); #1;
    in_data = d;
    in_sel = s;
    in_neg = n;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (mess) begin
      in_data = ~d;
      in_sel = ~s;
      in_neg = ~n;
      in_valid = 1'b1;
    end
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    chk("latency", 64'(lat), 64'(n ? 5 : 1));
    chk("out_data", 64'(out_data), 64'(ed));
    chk("out_carry", 64'(out_carry), 64'(ec));
    repeat (hold) begin
      @(negedge clk);
      chk("hold_valid", 64'(out_valid), 64'd1);
      chk("hold_result", 64'({out_carry, out_data}), 64'({ec, ed}));
      chk("hold_in_ready", 64'(in_ready), 64'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
  endtask

  initial begin
    #3;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_carry", 64'(out_carry), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(32'hFFFFFFFA, 4'hF, 1'b1, 32'hFFFFFFFB, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFFF, 4'hF, 1'b1, 32'h00000000, 1'b1, 0, 1'b0);
    run_op(32'h00FF00FF, 4'b0101, 1'b1, 32'h00000000, 1'b1, 0, 1'b0);
    run_op(32'h000000FF, 4'b0011, 1'b1, 32'h00000100, 1'b0, 0, 1'b0);
    run_op(32'h12345678, 4'hF, 1'b0, 32'h12345678, 1'b0, 0, 1'b0);
    run_op(32'hFFFFFFFA, 4'hF, 1'b1, 32'hFFFFFFFB, 1'b0, 3, 1'b0);
    run_op(32'h00000000, 4'h0, 1'b1, 32'h00000000, 1'b1, 0, 1'b0);
    run_op(32'hFF000000, 4'b1000, 1'b1, 32'h00000000, 1'b1, 0, 1'b1);
    run_op(32'h12003400, 4'b1010, 1'b1, 32'h12003500, 1'b0, 1, 1'b1);
    run_op(32'h00FFFF00, 4'b0110, 1'b1, 32'h00000000, 1'b1, 0, 1'b0);
    run_op(32'h0000FE00, 4'b0010, 1'b1, 32'h0000FF00, 1'b0, 0, 1'b1);
    run_op(32'hCAFEBABE, 4'b0101, 1'b0, 32'hCAFEBABE, 1'b0, 2, 1'b1);

    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle_ready_hi_valid", 64'(out_valid), 64'd0);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;

    @(posedge clk); #1;
    in_data = 32'hFFFFFFFA;
    in_sel = 4'hF;
    in_neg = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_out_data", 64'(out_data), 64'd0);
    chk("midrst_out_carry", 64'(out_carry), 64'd0);
    run_op(32'hFFFFFFFA, 4'hF, 1'b1, 32'hFFFFFFFB, 1'b0, 0, 1'b0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
